// File: rtl/nb_sign_pkg.sv
// Shared definitions for the sign-manipulation unit: transaction mode encodings.
package nb_sign_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_CNEG = 2'b11;

endpackage : nb_sign_pkg

// File: rtl/nb_sign_lane.sv
// One N-bit lane: optional two's-complement negation with most-negative detection.
module nb_sign_lane #(
  parameter int unsigned N   = 16,
  parameter int unsigned SAT = 1
) (
  input  logic [N-1:0] i_x,
  input  logic         i_neg,
  output logic [N-1:0] o_r,
  output logic         o_ovf
);

  localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MaxVal = {1'b0, {(N-1){1'b1}}};

  logic         w_is_min;
  logic [N-1:0] w_negated;

  assign w_is_min  = (i_x == MinVal);
  assign w_negated = ~i_x + {{(N-1){1'b0}}, 1'b1};

  // Select pass or negate; negating MIN is the only overflow case.
  always_comb begin
    o_r   = i_x;
    o_ovf = 1'b0;
    if (i_neg) begin
      if (w_is_min) begin
        o_ovf = 1'b1;
        o_r   = (SAT != 0) ? MaxVal : MinVal;
      end else begin
        o_r = w_negated;
      end
    end
  end

endmodule : nb_sign_lane

// File: rtl/nb_sign_unit.sv
// Multi-lane sign unit: per-lane negate/abs with a 1-deep valid/ready output register
// and a saturating count of transactions that overflowed.
module nb_sign_unit
  import nb_sign_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned LANES = 2,
  parameter int unsigned SAT   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [LANES-1:0]     in_neg,
  input  logic [N*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*LANES-1:0]   out_data,
  output logic [LANES-1:0]     out_ovf,
  output logic [CNT_W-1:0]     ovf_count,
  input  logic                 cnt_clr
);

  logic                 r_out_valid;
  logic [N*LANES-1:0]   r_out_data;
  logic [LANES-1:0]     r_out_ovf;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_fire;
  logic                 w_xfer;
  logic [LANES-1:0]     w_neg_sel;
  logic [N*LANES-1:0]   w_res;
  logic [LANES-1:0]     w_ovf;

  assign in_ready = !r_out_valid || out_ready;
  assign w_fire   = in_valid && in_ready;
  assign w_xfer   = r_out_valid && out_ready;

  // Decode the transaction mode into a per-lane negate select.
  always_comb begin
    w_neg_sel = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      unique case (in_mode)
        MODE_PASS: w_neg_sel[k] = 1'b0;
        MODE_NEG:  w_neg_sel[k] = 1'b1;
        MODE_ABS:  w_neg_sel[k] = in_data[k*N + N - 1];
        MODE_CNEG: w_neg_sel[k] = in_neg[k];
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nb_sign_lane #(
      .N   (N),
      .SAT (SAT)
    ) u_lane (
      .i_x   (in_data[g*N +: N]),
      .i_neg (w_neg_sel[g]),
      .o_r   (w_res[g*N +: N]),
      .o_ovf (w_ovf[g])
    );
  end

  // Output register: load on fire, drop valid on transfer, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_ovf   <= w_ovf;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Overflow event counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_fire && (|w_ovf) && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign ovf_count = r_cnt;

endmodule : nb_sign_unit
